// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage pipeline: per-stage hold/bubble vectors from hazard requests,
// with an FSM sequencing multi-cycle MUL/DIV and data-memory waits.
module pipe_hazard_ctrl #(
    parameter int MDU_LAT     = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_use,
    input  logic        branch_taken,
    input  logic        mdu_start,
    input  logic        mem_wait,
    output logic [5:0]  stall,
    output logic [5:0]  flush,
    output logic        busy,
    output logic        mem_timeout,
    output logic [31:0] stall_cycles
);

    localparam int CW = $clog2(MDU_LAT + 1);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] MDU_LOAD = CW'(MDU_LAT - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(MEM_TIMEOUT);

    localparam logic [5:0] MEMP_STALL = 6'b001111, MEMP_FLUSH = 6'b010000;
    localparam logic [5:0] MDUP_STALL = 6'b000111, MDUP_FLUSH = 6'b001000;
    localparam logic [5:0] BRP_FLUSH  = 6'b000110;
    localparam logic [5:0] LUP_STALL  = 6'b000011, LUP_FLUSH  = 6'b000100;

    typedef enum logic [1:0] {IDLE, MDU, MEMW} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] mdu_cnt, mdu_cnt_nxt;
    logic [WW-1:0] wait_cnt, wait_cnt_nxt;
    logic [5:0]    stall_raw, flush_raw;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;
        stall_raw   = '0;
        flush_raw   = '0;
        if (state == MDU) begin
            // Inside an MDU op only a memory wait can preempt; upstream requests are frozen.
            if (mem_wait) begin
                stall_raw = MEMP_STALL;
                flush_raw = MEMP_FLUSH;
            end else begin
                stall_raw   = MDUP_STALL;
                flush_raw   = MDUP_FLUSH;
                mdu_cnt_nxt = mdu_cnt - 1'b1;
                if (mdu_cnt == CW'(1)) state_nxt = IDLE;
            end
        end else if (mem_wait) begin
            stall_raw = MEMP_STALL;
            flush_raw = MEMP_FLUSH;
            state_nxt = MEMW;
        end else if (mdu_start) begin
            stall_raw = MDUP_STALL;
            flush_raw = MDUP_FLUSH;
            if (MDU_LAT > 1) begin
                state_nxt   = MDU;
                mdu_cnt_nxt = MDU_LOAD;
            end else begin
                state_nxt = IDLE;
            end
        end else if (branch_taken) begin
            flush_raw = BRP_FLUSH;
            state_nxt = IDLE;
        end else if (load_use) begin
            stall_raw = LUP_STALL;
            flush_raw = LUP_FLUSH;
            state_nxt = IDLE;
        end else begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        wait_cnt_nxt = '0;
        if (mem_wait) wait_cnt_nxt = (wait_cnt == WAIT_MAX) ? wait_cnt : wait_cnt + 1'b1;
    end

    // Outputs are forced quiet while reset is asserted, independent of the clock.
    assign stall = rst_n ? stall_raw : '0;
    assign flush = rst_n ? flush_raw : '0;
    assign busy  = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            mdu_cnt      <= '0;
            wait_cnt     <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state        <= state_nxt;
            mdu_cnt      <= mdu_cnt_nxt;
            wait_cnt     <= wait_cnt_nxt;
            mem_timeout  <= mem_timeout | (wait_cnt_nxt == WAIT_MAX);
            stall_cycles <= stall_cycles + {31'd0, stall_raw[0]};
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: a cycle-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_hazard_ctrl;

    localparam int LAT = 4;
    localparam int TMO = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_use = 1'b0, branch_taken = 1'b0, mdu_start = 1'b0, mem_wait = 1'b0;
    logic [5:0]  stall, flush;
    logic        busy, mem_timeout;
    logic [31:0] stall_cycles;

    int n_checks = 0;
    int n_errors = 0;

    pipe_hazard_ctrl #(.MDU_LAT(LAT), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .load_use(load_use), .branch_taken(branch_taken),
        .mdu_start(mdu_start), .mem_wait(mem_wait), .stall(stall), .flush(flush),
        .busy(busy), .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: remaining MUL/DIV cycles, consecutive-wait run, and whether the
    // previous cycle was a memory wait taken outside an MDU op (that is what keeps busy high).
    int          m_left = 0, m_wait = 0, m_sc = 0;
    bit          m_to = 0, m_memw = 0;
    logic [5:0]  es, ef;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            m_left = 0; m_wait = 0; m_sc = 0; m_to = 0; m_memw = 0;
        end
        if (!rst_n)                          begin es = 6'b000000; ef = 6'b000000; end
        else if (mem_wait)                   begin es = 6'b001111; ef = 6'b010000; end
        else if (m_left > 0 || mdu_start)    begin es = 6'b000111; ef = 6'b001000; end
        else if (branch_taken)               begin es = 6'b000000; ef = 6'b000110; end
        else if (load_use)                   begin es = 6'b000011; ef = 6'b000100; end
        else                                 begin es = 6'b000000; ef = 6'b000000; end
        check("model_stall", {26'd0, stall}, {26'd0, es});
        check("model_flush", {26'd0, flush}, {26'd0, ef});
        check("model_busy", {31'd0, busy}, {31'd0, (m_left > 0 || m_memw)});
        check("model_timeout", {31'd0, mem_timeout}, {31'd0, m_to});
        check("model_stall_cycles", stall_cycles, m_sc);
        if (rst_n) begin
            bit nm;
            m_sc += es[0];
            if (mem_wait) begin
                m_wait = (m_wait + 1 > TMO) ? TMO : m_wait + 1;
                if (m_wait == TMO) m_to = 1;
            end else begin
                m_wait = 0;
            end
            nm = mem_wait && (m_left == 0);
            if (!mem_wait) begin
                if (m_left > 0) m_left--;
                else if (mdu_start) m_left = LAT - 1;
            end
            m_memw = nm;
        end
    end

    // One cycle of stimulus; returns with the combinational response settled.
    task automatic cyc(input bit lu, input bit br, input bit ms, input bit mw);
        @(posedge clk);
        #1;
        load_use = lu; branch_taken = br; mdu_start = ms; mem_wait = mw;
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0; load_use = 0; branch_taken = 0; mdu_start = 0; mem_wait = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of a MUL/DIV op
        cyc(0, 0, 1, 0);
        check("t1_mdu_c0_stall", {26'd0, stall}, 32'b000111);
        check("t1_mdu_c0_busy", {31'd0, busy}, 32'd0);
        cyc(0, 0, 0, 0);
        check("t1_mdu_c1_busy", {31'd0, busy}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b0; load_use = 0; branch_taken = 0; mdu_start = 0; mem_wait = 0;
        #1;
        check("t1_rst_stall", {26'd0, stall}, 32'd0);
        check("t1_rst_flush", {26'd0, flush}, 32'd0);
        check("t1_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 0, 0, 0);
        check("t1_post_stall", {26'd0, stall}, 32'd0);
        check("t1_post_busy", {31'd0, busy}, 32'd0);
        check("t1_post_sc", stall_cycles, 32'd0);

        // Load-use alone, then squashed by a taken branch
        cyc(1, 0, 0, 0);
        check("t2_lu_stall", {26'd0, stall}, 32'b000011);
        check("t2_lu_flush", {26'd0, flush}, 32'b000100);
        cyc(1, 1, 0, 0);
        check("t2_br_stall", {26'd0, stall}, 32'd0);
        check("t2_br_flush", {26'd0, flush}, 32'b000110);
        check("t2_sc", stall_cycles, 32'd1);

        // Plain MUL/DIV op: exactly LAT stall cycles
        do_reset();
        cyc(0, 0, 1, 0);
        check("t3_c0_flush", {26'd0, flush}, 32'b001000);
        for (int i = 1; i < LAT; i++) begin
            cyc(0, 0, 0, 0);
            check("t3_mid_stall", {26'd0, stall}, 32'b000111);
            check("t3_mid_busy", {31'd0, busy}, 32'd1);
        end
        cyc(0, 0, 0, 0);
        check("t3_end_stall", {26'd0, stall}, 32'd0);
        check("t3_end_busy", {31'd0, busy}, 32'd0);
        check("t3_sc", stall_cycles, 32'd4);

        // MUL/DIV interrupted by two memory-wait cycles; requests inside MDU are ignored
        do_reset();
        cyc(0, 0, 1, 0);
        cyc(1, 1, 1, 0);
        check("t4_ignored_stall", {26'd0, stall}, 32'b000111);
        cyc(0, 0, 0, 1);
        check("t4_memp_stall", {26'd0, stall}, 32'b001111);
        check("t4_memp_flush", {26'd0, flush}, 32'b010000);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 0);
        check("t4_resume_stall", {26'd0, stall}, 32'b000111);
        cyc(0, 0, 0, 0);
        check("t4_last_busy", {31'd0, busy}, 32'd1);
        cyc(0, 0, 0, 0);
        check("t4_idle_stall", {26'd0, stall}, 32'd0);
        check("t4_idle_busy", {31'd0, busy}, 32'd0);
        check("t4_sc", stall_cycles, 32'd6);

        // Memory timeout after three consecutive wait cycles, sticky afterwards
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, 1);
            check("t5_stall", {26'd0, stall}, 32'b001111);
            check("t5_timeout", {31'd0, mem_timeout}, (i >= 3) ? 32'd1 : 32'd0);
        end
        cyc(0, 0, 0, 0);
        check("t5_drop_timeout", {31'd0, mem_timeout}, 32'd1);
        check("t5_drop_busy", {31'd0, busy}, 32'd1);
        cyc(0, 0, 0, 0);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        check("t5_sc", stall_cycles, 32'd5);

        // Wait ends on the same cycle as a taken branch
        do_reset();
        cyc(0, 0, 0, 1);
        cyc(0, 1, 0, 0);
        check("t6_br_stall", {26'd0, stall}, 32'd0);
        check("t6_br_flush", {26'd0, flush}, 32'b000110);
        check("t6_br_busy", {31'd0, busy}, 32'd1);
        cyc(0, 0, 0, 0);
        check("t6_idle_busy", {31'd0, busy}, 32'd0);
        check("t6_timeout", {31'd0, mem_timeout}, 32'd0);

        repeat (2) cyc(0, 0, 0, 0);
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
